filter_coef_loader: RTL and testbench



---
 rtl/synth_pkg.sv | 19 +
 rtl/filter_coef_loader.sv | 117 +++++++++++
 tb/tb_filter_coef_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/synth_pkg.sv
// synth_pkg: shared types and constants for the synth voice datapath.
package synth_pkg;

    localparam int COEF_W = 16;

    typedef enum logic [1:0] {IDLE, FETCH, WAIT_TICK, COMMIT} coef_ld_state_t;

    // Coefficient slot order as laid out in the coefficient ROM
    localparam logic [2:0] SEL_B0 = 3'd0;
    localparam logic [2:0] SEL_B1 = 3'd1;
    localparam logic [2:0] SEL_B2 = 3'd2;
    localparam logic [2:0] SEL_A0 = 3'd3;
    localparam logic [2:0] SEL_A1 = 3'd4;
    localparam logic [2:0] SEL_A2 = 3'd5;

    localparam logic [COEF_W-1:0] COEF_ONE  = 16'hFFFF;
    localparam logic [COEF_W-1:0] COEF_ZERO = '0;

endpackage

// File: rtl/filter_coef_loader.sv
// filter_coef_loader: fetches a six-word biquad coefficient set from ROM into
// shadow registers and commits it to the live outputs atomically on a sample tick.
module filter_coef_loader #(
    parameter int IDX_W  = 6,
    parameter int COEF_W = synth_pkg::COEF_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req,
    input  logic [IDX_W-1:0]  cutoff_idx,
    input  logic              sample_tick,
    output logic [IDX_W+2:0]  rom_addr,
    input  logic [COEF_W-1:0] rom_data,
    output logic [COEF_W-1:0] b0,
    output logic [COEF_W-1:0] b1,
    output logic [COEF_W-1:0] b2,
    output logic [COEF_W-1:0] a0,
    output logic [COEF_W-1:0] a1,
    output logic [COEF_W-1:0] a2,
    output logic              busy,
    output logic              committed
);
    import synth_pkg::*;

    coef_ld_state_t    state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              pend_q, pend_d;
    logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;
    logic [IDX_W+2:0]  rom_addr_q, rom_addr_d;
    logic              committed_q, committed_d;
    logic [COEF_W-1:0] shadow_q [6];
    logic [COEF_W-1:0] shadow_d [6];
    logic [COEF_W-1:0] live_q [6];
    logic [COEF_W-1:0] live_d [6];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        pend_d      = pend_q;
        pend_idx_d  = pend_idx_q;
        shadow_d    = shadow_q;
        live_d      = live_q;
        committed_d = (state_q == COMMIT);
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = FETCH;
                    idx_d   = cutoff_idx;
                    cnt_d   = 3'd0;
                end
            end
            FETCH: begin
                // ROM read latency is one cycle, so slot cnt-1 arrives while cnt is on the bus
                if (cnt_q != 3'd0)
                    shadow_d[cnt_q - 3'd1] = rom_data;
                cnt_d   = (cnt_q == SEL_A2 + 3'd1) ? 3'd0 : cnt_q + 3'd1;
                state_d = (cnt_q == SEL_A2 + 3'd1) ? WAIT_TICK : FETCH;
            end
            WAIT_TICK: state_d = sample_tick ? COMMIT : WAIT_TICK;
            COMMIT: begin
                live_d  = shadow_q;
                state_d = IDLE;
                // A request landing in this very cycle is newer than any stored one
                if (req || pend_q) begin
                    state_d = FETCH;
                    cnt_d   = 3'd0;
                    idx_d   = req ? cutoff_idx : pend_idx_q;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (req && (state_q == FETCH || state_q == WAIT_TICK)) begin
            pend_d     = 1'b1;
            pend_idx_d = cutoff_idx;
        end
        rom_addr_d = (state_d == FETCH && cnt_d <= SEL_A2) ? {idx_d, cnt_d} : rom_addr_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_q      <= 1'b0;
            pend_idx_q  <= '0;
            rom_addr_q  <= '0;
            committed_q <= 1'b0;
            shadow_q    <= '{default: '0};
            live_q      <= '{COEF_W'(COEF_ONE), COEF_W'(COEF_ZERO), COEF_W'(COEF_ZERO),
                            COEF_W'(COEF_ONE), COEF_W'(COEF_ZERO), COEF_W'(COEF_ZERO)};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_q      <= pend_d;
            pend_idx_q  <= pend_idx_d;
            rom_addr_q  <= rom_addr_d;
            committed_q <= committed_d;
            shadow_q    <= shadow_d;
            live_q      <= live_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign busy      = (state_q != IDLE);
    assign committed = committed_q;
    assign b0        = live_q[SEL_B0];
    assign b1        = live_q[SEL_B1];
    assign b2        = live_q[SEL_B2];
    assign a0        = live_q[SEL_A0];
    assign a1        = live_q[SEL_A1];
    assign a2        = live_q[SEL_A2];

endmodule

// File: tb/tb_filter_coef_loader.sv
// tb_filter_coef_loader: directed checks of fetch timing, atomic commit, pending
// requests and reset, followed by a randomized consistency run.
module tb_filter_coef_loader;

    logic        Clk;
    logic        Reset;
    logic        req;
    logic [5:0]  cutoff_idx;
    logic        sample_tick;
    logic [8:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] b0, b1, b2, a0, a1, a2;
    logic        busy;
    logic        committed;

    int passed = 0;
    int total  = 0;
    bit seen9  = 0;

    filter_coef_loader #(.IDX_W(6), .COEF_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .cutoff_idx(cutoff_idx),
        .sample_tick(sample_tick), .rom_addr(rom_addr), .rom_data(rom_data),
        .b0(b0), .b1(b1), .b2(b2), .a0(a0), .a1(a1), .a2(a2),
        .busy(busy), .committed(committed)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Coefficient ROM stand-in: word encodes its own index and slot
    always @(posedge Clk) begin
        rom_data <= {rom_addr[8:3], rom_addr[2:0], 7'h55};
        if (rom_addr[8:3] == 6'd9) seen9 <= 1'b1;
    end

    function automatic logic [15:0] w(input logic [5:0] idx, input logic [2:0] sel);
        return {idx, sel, 7'h55};
    endfunction

    task automatic tick_clk;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_pass(input string tag);
        chk({tag, "_b0"}, 32'(b0), 32'hFFFF);
        chk({tag, "_b1"}, 32'(b1), 32'h0);
        chk({tag, "_b2"}, 32'(b2), 32'h0);
        chk({tag, "_a0"}, 32'(a0), 32'hFFFF);
        chk({tag, "_a1"}, 32'(a1), 32'h0);
        chk({tag, "_a2"}, 32'(a2), 32'h0);
    endtask

    task automatic check_live(input string tag, input logic [5:0] idx);
        chk({tag, "_b0"}, 32'(b0), 32'(w(idx, 3'd0)));
        chk({tag, "_b1"}, 32'(b1), 32'(w(idx, 3'd1)));
        chk({tag, "_b2"}, 32'(b2), 32'(w(idx, 3'd2)));
        chk({tag, "_a0"}, 32'(a0), 32'(w(idx, 3'd3)));
        chk({tag, "_a1"}, 32'(a1), 32'(w(idx, 3'd4)));
        chk({tag, "_a2"}, 32'(a2), 32'(w(idx, 3'd5)));
    endtask

    initial begin
        logic [95:0] prev_set, cur_set;
        logic        consistent;
        Reset = 1'b1; req = 1'b0; cutoff_idx = '0; sample_tick = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_pass("rst_hold");
        Reset = 1'b0;
        tick_clk;
        check_pass("rst");
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_committed", 32'(committed), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);

        // Load idx 5; ticks during FETCH are ignored, commit only on a later tick
        cutoff_idx = 6'd5; req = 1'b1;
        tick_clk;
        req = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k <= 6) chk("addr_fetch", 32'(rom_addr), 32'({6'd5, 3'(k - 1)}));
            else        chk("addr_hold", 32'(rom_addr), 32'({6'd5, 3'd5}));
            chk("busy_load", 32'(busy), 32'd1);
            chk("live_hold_b0", 32'(b0), 32'hFFFF);
            chk("live_hold_a1", 32'(a1), 32'h0);
            chk("no_commit", 32'(committed), 32'd0);
            sample_tick = (k == 3 || k == 5 || k == 20);
            tick_clk;
        end
        sample_tick = 1'b0;
        chk("commit_cyc_busy", 32'(busy), 32'd1);
        chk("commit_cyc_b1", 32'(b1), 32'h0);
        chk("commit_cyc_pulse", 32'(committed), 32'd0);
        tick_clk;
        check_live("load5", 6'd5);
        chk("load5_pulse", 32'(committed), 32'd1);
        chk("load5_busy", 32'(busy), 32'd0);
        chk("load5_addr", 32'(rom_addr), 32'({6'd5, 3'd5}));
        tick_clk;
        chk("load5_pulse_end", 32'(committed), 32'd0);
        check_live("load5_keep", 6'd5);

        // Pending requests: idx 3 commits, then the latest (12) replaces 9
        cutoff_idx = 6'd3; req = 1'b1;
        tick_clk;
        req = 1'b0; sample_tick = 1'b1;
        tick_clk;
        req = 1'b1; cutoff_idx = 6'd9;
        tick_clk;
        req = 1'b0;
        tick_clk;
        req = 1'b1; cutoff_idx = 6'd12;
        tick_clk;
        req = 1'b0;
        repeat (4) tick_clk;
        chk("pend_commit_pulse", 32'(committed), 32'd0);
        chk("pend_commit_busy", 32'(busy), 32'd1);
        chk("pend_old_b0", 32'(b0), 32'(w(6'd5, 3'd0)));
        tick_clk;
        check_live("load3", 6'd3);
        chk("load3_pulse", 32'(committed), 32'd1);
        chk("load3_busy", 32'(busy), 32'd1);
        chk("pend_addr", 32'(rom_addr), 32'({6'd12, 3'd0}));
        repeat (8) tick_clk;
        chk("load12_pre_pulse", 32'(committed), 32'd0);
        chk("load12_pre_busy", 32'(busy), 32'd1);
        chk("load12_pre_a1", 32'(a1), 32'(w(6'd3, 3'd4)));
        tick_clk;
        check_live("load12", 6'd12);
        chk("load12_pulse", 32'(committed), 32'd1);
        chk("load12_busy", 32'(busy), 32'd0);
        sample_tick = 1'b0;
        chk("idx9_unseen", 32'(seen9), 32'd0);

        // Request in the COMMIT cycle chains straight into the next FETCH
        cutoff_idx = 6'd7; req = 1'b1;
        tick_clk;
        req = 1'b0;
        repeat (7) tick_clk;
        sample_tick = 1'b1;
        tick_clk;
        sample_tick = 1'b0; req = 1'b1; cutoff_idx = 6'd20;
        chk("chain_commit_busy", 32'(busy), 32'd1);
        tick_clk;
        req = 1'b0;
        check_live("load7", 6'd7);
        chk("load7_pulse", 32'(committed), 32'd1);
        chk("chain_busy", 32'(busy), 32'd1);
        chk("chain_addr", 32'(rom_addr), 32'({6'd20, 3'd0}));
        for (int k = 11; k <= 17; k++) begin
            tick_clk;
            chk("chain_busy_hold", 32'(busy), 32'd1);
        end
        sample_tick = 1'b1;
        tick_clk;
        sample_tick = 1'b0;
        chk("chain2_commit_busy", 32'(busy), 32'd1);
        chk("chain2_old_b0", 32'(b0), 32'(w(6'd7, 3'd0)));
        tick_clk;
        check_live("load20", 6'd20);
        chk("load20_busy", 32'(busy), 32'd0);

        // Reset mid-FETCH abandons the load and restores passthrough
        cutoff_idx = 6'd30; req = 1'b1;
        tick_clk;
        req = 1'b0;
        tick_clk;
        #2 Reset = 1'b1;
        #1;
        check_pass("midrst");
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_addr", 32'(rom_addr), 32'd0);
        chk("midrst_committed", 32'(committed), 32'd0);
        #2 Reset = 1'b0;
        sample_tick = 1'b1;
        repeat (12) tick_clk;
        sample_tick = 1'b0;
        chk("midrst_idle_busy", 32'(busy), 32'd0);
        chk("midrst_idle_pulse", 32'(committed), 32'd0);
        check_pass("midrst_after");

        // Random requests and ticks: live set is never mixed, and every change pulses committed
        prev_set = {b0, b1, b2, a0, a1, a2};
        for (int c = 0; c < 3000; c++) begin
            req         = ($urandom_range(0, 19) == 0);
            cutoff_idx  = 6'($urandom_range(0, 63));
            sample_tick = ($urandom_range(0, 15) == 0);
            tick_clk;
            cur_set = {b0, b1, b2, a0, a1, a2};
            consistent = (cur_set == {16'hFFFF, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0}) ||
                         (cur_set == {w(b0[15:10], 3'd0), w(b0[15:10], 3'd1), w(b0[15:10], 3'd2),
                                      w(b0[15:10], 3'd3), w(b0[15:10], 3'd4), w(b0[15:10], 3'd5)});
            chk("rand_mixed", 32'(consistent), 32'd1);
            if (cur_set != prev_set) chk("rand_change_pulse", 32'(committed), 32'd1);
            prev_set = cur_set;
        end
        req = 1'b0; sample_tick = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
